// File: rtl/storage_arbiter.sv
// Shared row memory with one write port and a single registered read port
// arbitrated among AMT_READER channels (fixed priority or round-robin).
//
// state | meaning
// IDLE  | no grants issued, requests ignored; writes still land (preload)
// RUN   | arbitration active until reset; startSig ignored
module storage_arbiter #(
  parameter int READ_ADDR_SIZE = 10,
  parameter int ROW_WIDTH      = 32,
  parameter int AMT_READER     = 4,
  parameter int RR_MODE        = 0,
  parameter int BYPASS         = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 startSig,
  input  logic [READ_ADDR_SIZE*AMT_READER-1:0] readAddrs,
  input  logic [AMT_READER-1:0]                readReqs,
  input  logic [READ_ADDR_SIZE-1:0]            writeAddr,
  input  logic [ROW_WIDTH-1:0]                 writeData,
  input  logic                                 writeEn,
  output logic [AMT_READER-1:0]                readGrant,
  output logic [AMT_READER-1:0]                readValid,
  output logic [ROW_WIDTH-1:0]                 readData
);

  localparam int PTR_W = (AMT_READER > 1) ? $clog2(AMT_READER) : 1;
  localparam int DEPTH = 2 ** READ_ADDR_SIZE;
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(AMT_READER - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                    state, state_nxt;
  logic                      run;
  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          base;
  logic [PTR_W-1:0]          grant_idx;
  logic                      grant_any;
  logic [READ_ADDR_SIZE-1:0] grant_addr;
  logic [ROW_WIDTH-1:0]      mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE && startSig) state_nxt = RUN;
  end

  always_comb begin
    run = (state == RUN);
  end

  // Fixed priority is round-robin with the search start pinned to channel 0.
  assign base = (RR_MODE != 0) ? rr_ptr : '0;

  // First pass scans channels at/after the start point, second pass wraps.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_addr = '0;
    for (int i = 0; i < AMT_READER; i++) begin
      if (!grant_any && run && readReqs[i] && i >= int'(base)) begin
        grant_any  = 1'b1;
        grant_idx  = PTR_W'(i);
        grant_addr = readAddrs[i*READ_ADDR_SIZE +: READ_ADDR_SIZE];
      end
    end
    for (int i = 0; i < AMT_READER; i++) begin
      if (!grant_any && run && readReqs[i] && i < int'(base)) begin
        grant_any  = 1'b1;
        grant_idx  = PTR_W'(i);
        grant_addr = readAddrs[i*READ_ADDR_SIZE +: READ_ADDR_SIZE];
      end
    end
  end

  always_comb begin
    readGrant = '0;
    if (grant_any) readGrant[grant_idx] = 1'b1;
  end

  // Memory rows are deliberately not reset so preloaded content survives rst.
  always_ff @(posedge clk) begin
    if (writeEn) mem[writeAddr] <= writeData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readValid <= '0;
      readData  <= '0;
      rr_ptr    <= '0;
    end else begin
      readValid <= readGrant;
      if (grant_any) begin
        if (BYPASS != 0 && writeEn && writeAddr == grant_addr) readData <= writeData;
        else                                                   readData <= mem[grant_addr];
        if (RR_MODE != 0) rr_ptr <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_storage_arbiter.sv
// Bench for storage_arbiter: a fixed/bypass instance and a round-robin/no-bypass
// instance share stimulus and are checked against a per-channel reference model.
module tb_storage_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startSig = 1'b0;
  logic [39:0] readAddrs = '0;
  logic [3:0]  readReqs = '0;
  logic [9:0]  writeAddr = '0;
  logic [31:0] writeData = '0;
  logic        writeEn = 1'b0;
  logic [3:0]  gnt_f, vld_f, gnt_r, vld_r;
  logic [31:0] dat_f, dat_r;

  int n_pass = 0;
  int n_total = 0;

  bit          m_run;
  int          m_ptr;
  logic [31:0] mem_m [int];
  logic [3:0]  ev_f, ev_r;
  logic [31:0] ed_f, ed_r;

  typedef struct {
    logic       start;
    logic [3:0] reqs;
    logic [3:0] g_fix;
    logic [3:0] g_rr;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  storage_arbiter #(.RR_MODE(0), .BYPASS(1)) dut_fix (
    .clk(clk), .rst(rst), .startSig(startSig), .readAddrs(readAddrs), .readReqs(readReqs),
    .writeAddr(writeAddr), .writeData(writeData), .writeEn(writeEn),
    .readGrant(gnt_f), .readValid(vld_f), .readData(dat_f)
  );

  storage_arbiter #(.RR_MODE(1), .BYPASS(0)) dut_rr (
    .clk(clk), .rst(rst), .startSig(startSig), .readAddrs(readAddrs), .readReqs(readReqs),
    .writeAddr(writeAddr), .writeData(writeData), .writeEn(writeEn),
    .readGrant(gnt_r), .readValid(vld_r), .readData(dat_r)
  );

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%b required=%b", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [3:0] exp_grant(input bit rr, input int ptr, input logic [3:0] reqs, input bit active);
    logic [3:0] r = '0;
    int c;
    if (active) begin
      for (int k = 0; k < 4; k++) begin
        c = rr ? (ptr + k) % 4 : k;
        if (reqs[c] && r == 4'b0000) r[c] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    int r = 0;
    for (int k = 0; k < 4; k++) if (v[k]) r = k;
    return r;
  endfunction

  function automatic logic [31:0] read_value(input int ch, input bit byp);
    int a;
    a = int'(readAddrs[ch*10 +: 10]);
    if (byp && writeEn && int'(writeAddr) == a) return writeData;
    return mem_m[a];
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_ptr = 0;
    ev_f = '0;
    ev_r = '0;
    ed_f = '0;
    ed_r = '0;
  endtask

  task automatic set_addrs(input int a0, input int a1, input int a2, input int a3);
    readAddrs = {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endtask

  // One clock: check combinational grants, advance model, check registered outputs.
  task automatic tick();
    logic [3:0] gf, gr;
    #1;
    gf = exp_grant(1'b0, 0, readReqs, m_run);
    gr = exp_grant(1'b1, m_ptr, readReqs, m_run);
    chk4("grant_fixed", gnt_f, gf);
    chk4("grant_rr", gnt_r, gr);
    ev_f = gf;
    ev_r = gr;
    if (gf != 4'b0000) ed_f = read_value(oh_idx(gf), 1'b1);
    if (gr != 4'b0000) begin
      ed_r  = read_value(oh_idx(gr), 1'b0);
      m_ptr = (oh_idx(gr) + 1) % 4;
    end
    if (writeEn) mem_m[int'(writeAddr)] = writeData;
    if (startSig) m_run = 1'b1;
    @(posedge clk);
    #1;
    chk4("valid_fixed", vld_f, ev_f);
    chk32("data_fixed", dat_f, ed_f);
    chk4("valid_rr", vld_r, ev_r);
    chk32("data_rr", dat_r, ed_r);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'b1010, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b0, 4'b1010, 4'b0010, 4'b0010};
    vecs[2]  = '{1'b0, 4'b1000, 4'b1000, 4'b1000};
    vecs[3]  = '{1'b1, 4'b1111, 4'b0001, 4'b0001};
    vecs[4]  = '{1'b0, 4'b1111, 4'b0001, 4'b0010};
    vecs[5]  = '{1'b0, 4'b1111, 4'b0001, 4'b0100};
    vecs[6]  = '{1'b0, 4'b1111, 4'b0001, 4'b1000};
    vecs[7]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001};
    vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000};
    vecs[9]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001};
    vecs[10] = '{1'b0, 4'b0110, 4'b0010, 4'b0010};
    vecs[11] = '{1'b0, 4'b0101, 4'b0001, 4'b0100};

    model_reset();
    repeat (2) @(negedge clk);
    chk4("reset_valid", vld_f, 4'b0000);
    chk32("reset_data", dat_f, 32'h0);
    rst = 1'b0;

    // Preload rows 0..15 while idle
    for (int a = 0; a < 16; a++) begin
      writeEn   = 1'b1;
      writeAddr = 10'(a);
      writeData = (a == 5) ? 32'hA5A5A5A5 : (a == 7) ? 32'hDEADBEEF : $urandom;
      tick();
    end
    writeEn = 1'b0;

    // Requests before startSig must be ignored
    set_addrs(5, 0, 0, 0);
    readReqs = 4'b0001;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk4("idle_grant", gnt_f, 4'b0000);
      chk4("idle_valid", vld_f, 4'b0000);
      chk4("idle_valid_rr", vld_r, 4'b0000);
    end

    set_addrs(10, 11, 12, 13);
    foreach (vecs[i]) begin
      startSig = vecs[i].start;
      readReqs = vecs[i].reqs;
      #1;
      chk4($sformatf("vec%0d_grant_fixed", i), gnt_f, vecs[i].g_fix);
      chk4($sformatf("vec%0d_grant_rr", i), gnt_r, vecs[i].g_rr);
      tick();
      chk4($sformatf("vec%0d_valid_fixed", i), vld_f, vecs[i].g_fix);
      chk4($sformatf("vec%0d_valid_rr", i), vld_r, vecs[i].g_rr);
    end
    startSig = 1'b0;

    // Same-cycle write/read of row 7
    set_addrs(7, 0, 0, 0);
    readReqs  = 4'b0001;
    writeEn   = 1'b1;
    writeAddr = 10'd7;
    writeData = 32'h12345678;
    tick();
    chk32("bypass_on", dat_f, 32'h12345678);
    chk32("bypass_off", dat_r, 32'hDEADBEEF);
    writeEn = 1'b0;
    tick();
    chk32("after_write_rr", dat_r, 32'h12345678);

    for (int n = 0; n < 400; n++) begin
      readReqs = 4'($urandom);
      set_addrs($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      writeEn   = ($urandom_range(0, 2) == 0);
      writeAddr = 10'($urandom_range(0, 15));
      writeData = $urandom;
      startSig  = ($urandom_range(0, 9) == 0);
      tick();
    end
    startSig = 1'b0;
    writeEn  = 1'b0;

    // Reset asserted during a granting cycle
    readReqs = 4'b1111;
    tick();
    #1;
    chk4("pre_rst_grant", gnt_f, 4'b0001);
    chk4("pre_rst_valid", vld_f, 4'b0001);
    rst = 1'b1;
    #1;
    chk4("rst_valid_fixed", vld_f, 4'b0000);
    chk32("rst_data_fixed", dat_f, 32'h0);
    chk4("rst_valid_rr", vld_r, 4'b0000);
    chk32("rst_data_rr", dat_r, 32'h0);
    chk4("rst_grant_fixed", gnt_f, 4'b0000);
    chk4("rst_grant_rr", gnt_r, 4'b0000);
    model_reset();
    @(posedge clk);
    #1;
    chk4("rst_discard", vld_f, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    chk4("post_rst_idle", gnt_r, 4'b0000);
    startSig = 1'b1;
    tick();
    startSig = 1'b0;
    #1;
    chk4("restart_grant_fixed", gnt_f, 4'b0001);
    chk4("restart_grant_rr", gnt_r, 4'b0001);
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
